// File: rtl/count_monitor.sv
// count_monitor: checks that an observed counter only holds, steps +1, wraps max->0 or resets to 0.
// Latency: events seen on count_in at edge N appear as registered one-cycle pulses after edge N.
// No backpressure: samples every clk edge. Optional macro COUNT_MONITOR_ERR_CAPTURE_EN adds err_prev/err_got capture.
module count_monitor #(
    parameter int WIDTH  = 8,
    parameter int WRAP_W = 16,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  count_in,
    input  logic [WIDTH-1:0]  cmp_val,
    output logic              wrap_pulse,
    output logic              match_pulse,
    output logic              step_err,
    output logic [WRAP_W-1:0] wraps,
    output logic [ERR_W-1:0]  errs,
`ifdef COUNT_MONITOR_ERR_CAPTURE_EN
    output logic [WIDTH-1:0]  err_prev,
    output logic [WIDTH-1:0]  err_got,
`endif
    output logic              tracking
);

    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_nxt;
    logic [WIDTH-1:0] prev_inc;
    logic             is_hold;
    logic             is_wrap;
    logic             is_inc;
    logic             is_zero;
    logic             ev_wrap;
    logic             ev_match;
    logic             ev_err;

    // Step classification terms; prev+1 is deliberately truncated to WIDTH bits.
    always_comb begin
        prev_inc = prev + CNT_ONE;
        is_hold  = (count_in == prev);
        is_wrap  = (prev == CNT_MAX) && (count_in == '0);
        is_inc   = (count_in == prev_inc);
        is_zero  = (count_in == '0);
    end

    // Next state, next prev and event detection; events only exist in TRACK with en held high.
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        ev_wrap   = 1'b0;
        ev_match  = 1'b0;
        ev_err    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                // Capture a fresh reference so re-enabling never compares against a stale value.
                prev_nxt  = count_in;
                state_nxt = en ? TRACK : IDLE;
            end
            TRACK: begin
                if (!en) begin
                    // Leaving TRACK: prev is held and any event on this edge is dropped.
                    state_nxt = IDLE;
                end else begin
                    prev_nxt = count_in;
                    ev_wrap  = !is_hold && is_wrap;
                    ev_err   = !is_hold && !is_wrap && !is_inc && !is_zero;
                    ev_match = !is_hold && (count_in == cmp_val);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and reference value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            prev  <= prev_nxt;
        end
    end

    // Registered one-cycle event pulses and the TRACK status flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            step_err    <= 1'b0;
            tracking    <= 1'b0;
        end else begin
            wrap_pulse  <= ev_wrap;
            match_pulse <= ev_match;
            step_err    <= ev_err;
            tracking    <= (state_nxt == TRACK);
        end
    end

    // Saturating statistics; clr takes precedence over a coincident event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wraps <= '0;
            errs  <= '0;
        end else if (clr) begin
            wraps <= '0;
            errs  <= '0;
        end else begin
            if (ev_wrap && (wraps != WRAP_MAX)) begin
                wraps <= wraps + WRAP_ONE;
            end
            if (ev_err && (errs != ERR_MAX)) begin
                errs <= errs + ERR_ONE;
            end
        end
    end

`ifdef COUNT_MONITOR_ERR_CAPTURE_EN
    // Snapshot of the most recent illegal step; clr wins over a coincident error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_prev <= '0;
            err_got  <= '0;
        end else if (clr) begin
            err_prev <= '0;
            err_got  <= '0;
        end else if (ev_err) begin
            err_prev <= prev;
            err_got  <= count_in;
        end
    end
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a behavioural model pushes expected outputs per edge into a queue,
// which is popped and compared one edge later; extra directed checks cover the key scenarios.
// Works with or without COUNT_MONITOR_ERR_CAPTURE_EN.
module tb_count_monitor;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clr;
    logic [7:0]  count_in;
    logic [7:0]  cmp_val;
    logic        wrap_pulse;
    logic        match_pulse;
    logic        step_err;
    logic [15:0] wraps;
    logic [7:0]  errs;
    logic        tracking;
`ifdef COUNT_MONITOR_ERR_CAPTURE_EN
    logic [7:0]  err_prev;
    logic [7:0]  err_got;
`endif

    count_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clr         (clr),
        .count_in    (count_in),
        .cmp_val     (cmp_val),
        .wrap_pulse  (wrap_pulse),
        .match_pulse (match_pulse),
        .step_err    (step_err),
        .wraps       (wraps),
        .errs        (errs),
`ifdef COUNT_MONITOR_ERR_CAPTURE_EN
        .err_prev    (err_prev),
        .err_got     (err_got),
`endif
        .tracking    (tracking)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_no = 0;
    int w_seen = 0;
    int m_seen = 0;
    int e_seen = 0;
    int first_t = -1;

    logic [63:0] exp_q[$];

    // Reference model state (0 = idle, 1 = arm, 2 = track).
    int          m_state = 0;
    logic [7:0]  m_prev  = 8'h00;
    logic [15:0] m_wraps = 16'h0000;
    logic [7:0]  m_errs  = 8'h00;
    logic [7:0]  m_ep    = 8'h00;
    logic [7:0]  m_eg    = 8'h00;
    logic        m_w     = 1'b0;
    logic        m_m     = 1'b0;
    logic        m_e     = 1'b0;
    logic        m_t     = 1'b0;

    function automatic logic [63:0] dut_vec();
        logic [7:0] ep;
        logic [7:0] eg;
        ep = 8'h00;
        eg = 8'h00;
`ifdef COUNT_MONITOR_ERR_CAPTURE_EN
        ep = err_prev;
        eg = err_got;
`endif
        return {20'h0, wrap_pulse, match_pulse, step_err, tracking, wraps, errs, ep, eg};
    endfunction

    function automatic logic [63:0] model_vec();
        logic [7:0] ep;
        logic [7:0] eg;
        ep = 8'h00;
        eg = 8'h00;
`ifdef COUNT_MONITOR_ERR_CAPTURE_EN
        ep = m_ep;
        eg = m_eg;
`endif
        return {20'h0, m_w, m_m, m_e, m_t, m_wraps, m_errs, ep, eg};
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task model_step();
        int   ns;
        logic w;
        logic m;
        logic e;
        w = 1'b0;
        m = 1'b0;
        e = 1'b0;
        if (reset) begin
            m_state = 0;
            m_prev  = 8'h00;
            m_wraps = 16'h0000;
            m_errs  = 8'h00;
            m_ep    = 8'h00;
            m_eg    = 8'h00;
            m_t     = 1'b0;
        end else begin
            ns = m_state;
            if (m_state == 0) begin
                ns = en ? 1 : 0;
            end else if (m_state == 1) begin
                m_prev = count_in;
                ns = en ? 2 : 0;
            end else if (!en) begin
                ns = 0;
            end else begin
                if (count_in != m_prev) begin
                    m = (count_in == cmp_val);
                    if (m_prev == 8'hFF && count_in == 8'h00)
                        w = 1'b1;
                    else if (int'(count_in) == (int'(m_prev) + 1) % 256)
                        w = 1'b0;
                    else if (count_in == 8'h00)
                        w = 1'b0;
                    else
                        e = 1'b1;
                end
                if (e && !clr) begin
                    m_ep = m_prev;
                    m_eg = count_in;
                end
                m_prev = count_in;
            end
            if (clr) begin
                m_wraps = 16'h0000;
                m_errs  = 8'h00;
                m_ep    = 8'h00;
                m_eg    = 8'h00;
            end else begin
                if (w && m_wraps != 16'hFFFF) m_wraps = m_wraps + 16'd1;
                if (e && m_errs != 8'hFF) m_errs = m_errs + 8'd1;
            end
            m_state = ns;
            m_t = (ns == 2);
        end
        m_w = w;
        m_m = m;
        m_e = e;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, queue the model's prediction, compare one edge later.
    task automatic cyc(input logic r, input logic e, input logic c,
                       input logic [7:0] cnt, input logic [7:0] cv);
        logic [63:0] ex;
        @(negedge clk);
        reset    = r;
        en       = e;
        clr      = c;
        count_in = cnt;
        cmp_val  = cv;
        model_step();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        check($sformatf("cycle%0d", cyc_no), dut_vec(), ex);
        cyc_no++;
        w_seen += int'(wrap_pulse);
        m_seen += int'(match_pulse);
        e_seen += int'(step_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        count_in = 8'h00;
        cmp_val  = 8'h00;
        #2;
        check("reset_state", dut_vec(), 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'hEE);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'hEE);

        // Free-running counter for 300 cycles.
        w_seen = 0; e_seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1, 1'b0, i[7:0], 8'hEE);
            if (tracking && first_t < 0) first_t = i;
        end
        check("first_tracking_edge", 64'(first_t), 64'd1);
        check("run_wrap_pulses", 64'(w_seen), 64'd1);
        check("run_step_errs", 64'(e_seen), 64'd0);
        check("run_wraps", 64'(wraps), 64'd1);
        check("run_errs", 64'(errs), 64'd0);

        // Hold on cmp_val for 5 cycles: only the entry pulses.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h10);
        m_seen = 0;
        for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, i[7:0], 8'h10);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h10);
        for (int i = 17; i < 21; i++) cyc(1'b0, 1'b1, 1'b0, i[7:0], 8'h10);
        check("hold_match_pulses", 64'(m_seen), 64'd1);

        // Illegal jump 0x05 -> 0x09.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h10);
        for (int i = 1; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, i[7:0], 8'h10);
        e_seen = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'h09, 8'h10);
        check("jump_step_err", 64'(step_err), 64'd1);
        check("jump_errs", 64'(errs), 64'd1);
`ifdef COUNT_MONITOR_ERR_CAPTURE_EN
        check("jump_err_prev", 64'(err_prev), 64'h05);
        check("jump_err_got", 64'(err_got), 64'h09);
`endif
        cyc(1'b0, 1'b1, 1'b0, 8'h0A, 8'h10);
        check("jump_single_pulse", 64'(e_seen), 64'd1);

        // Counter reset observed at 0x40 is legal.
        for (int i = 11; i <= 64; i++) cyc(1'b0, 1'b1, 1'b0, i[7:0], 8'h10);
        w_seen = 0; e_seen = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h10);
        check("ctr_reset_no_err", 64'(e_seen), 64'd0);
        check("ctr_reset_no_wrap", 64'(w_seen), 64'd0);
        check("ctr_reset_wraps", 64'(wraps), 64'd1);

        // 300 illegal steps: error counter saturates.
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 1'b0, (i % 2 == 1) ? 8'h80 : 8'h20, 8'h10);
        check("errs_saturated", 64'(errs), 64'hFF);

        // clr coinciding with a wrap.
        cyc(1'b0, 1'b1, 1'b0, 8'hFE, 8'h10);
        cyc(1'b0, 1'b1, 1'b0, 8'hFF, 8'h10);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h10);
        check("clr_wrap_pulse", 64'(wrap_pulse), 64'd1);
        check("clr_wraps", 64'(wraps), 64'd0);
        check("clr_errs", 64'(errs), 64'd0);

        // Dropping en suppresses an illegal step; re-enable re-arms.
        e_seen = 0;
        cyc(1'b0, 1'b0, 1'b0, 8'h77, 8'h10);
        check("en_drop_no_err", 64'(step_err), 64'd0);
        check("en_drop_tracking", 64'(tracking), 64'd0);
        for (int i = 144; i < 150; i++) cyc(1'b0, 1'b1, 1'b0, i[7:0], 8'h10);
        check("rearm_no_err", 64'(e_seen), 64'd0);

        // Asynchronous reset in the middle of a TRACK cycle.
        cyc(1'b0, 1'b1, 1'b0, 8'h96, 8'h96);
        #2;
        reset = 1'b1;
        model_step();
        #1;
        check("async_reset", dut_vec(), 64'h0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h10);
        e_seen = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'h05, 8'h10);
        check("post_rst_arm", 64'(tracking), 64'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h06, 8'h10);
        check("post_rst_track", 64'(tracking), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'h07, 8'h10);
        cyc(1'b0, 1'b1, 1'b0, 8'h08, 8'h10);
        check("post_rst_no_err", 64'(e_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
